// File: rtl/transpose_frame_unpacker_if.sv
// transpose_frame_unpacker_if: capture-side stream from transpose plus valid/ready frame output
interface transpose_frame_unpacker_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic [WIDTH-1:0] data_o;
    logic             valid_o;
    logic             ready_i;
    logic             first_o;
    logic             last_o;
    logic             ovf_o;

    modport slave (
        input  data_i, valid_i, ready_i,
        output data_o, valid_o, first_o, last_o, ovf_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  data_o, valid_o, first_o, last_o, ovf_o
    );
endinterface

// File: rtl/transpose_frame_unpacker.sv
// transpose_frame_unpacker: ping-pong buffers transpose column frames and re-emits them on valid/ready
module transpose_frame_unpacker #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter bit REV_ORDER = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    transpose_frame_unpacker_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [2][DEPTH];
    logic [1:0]       full, full_nxt;
    logic             wr_bank, rd_bank, ovf;
    logic [AW-1:0]    wr_cnt, rd_cnt, rd_idx;
    logic             wr_en, wr_drop, wr_done, rd_xfer, rd_done;

    // Write and read sides only ever finish opposite banks, so both edits to full can apply together
    always_comb begin
        wr_en    = bus.valid_i & ~full[wr_bank];
        wr_drop  = bus.valid_i & full[wr_bank];
        wr_done  = wr_en & (&wr_cnt);
        rd_xfer  = full[rd_bank] & bus.ready_i;
        rd_done  = rd_xfer & (&rd_cnt);
        rd_idx   = REV_ORDER ? ~rd_cnt : rd_cnt;
        full_nxt = full;
        if (wr_done) full_nxt[wr_bank] = 1'b1;
        if (rd_done) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int w = 0; w < DEPTH; w++)
                    mem[b][w] <= '0;
        end else if (wr_en) begin
            mem[wr_bank][wr_cnt] <= bus.data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            ovf     <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_en) wr_cnt <= wr_cnt + 1'b1;
            if (wr_done) wr_bank <= ~wr_bank;
            if (wr_drop) ovf <= 1'b1;
            if (rd_xfer) rd_cnt <= rd_cnt + 1'b1;
            if (rd_done) rd_bank <= ~rd_bank;
        end
    end

    assign bus.valid_o = full[rd_bank];
    assign bus.data_o  = full[rd_bank] ? mem[rd_bank][rd_idx] : '0;
    assign bus.first_o = full[rd_bank] & (rd_cnt == '0);
    assign bus.last_o  = full[rd_bank] & (&rd_cnt);
    assign bus.ovf_o   = ovf;
endmodule

// File: tb/tb_transpose_frame_unpacker.sv
// tb_transpose_frame_unpacker: directed checks of capture, emission order, stalls, overflow and reset
module tb_transpose_frame_unpacker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    transpose_frame_unpacker_if #(.WIDTH(32)) b ();
    transpose_frame_unpacker_if #(.WIDTH(32)) r ();

    transpose_frame_unpacker #(.WIDTH(32), .DEPTH(32), .REV_ORDER(1'b0)) u_fwd (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );
    transpose_frame_unpacker #(.WIDTH(32), .DEPTH(32), .REV_ORDER(1'b1)) u_rev (
        .clk(clk), .rst_n(rst_n), .bus(r)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        b.valid_i = 1'b0; b.data_i = '0; b.ready_i = 1'b0;
        r.valid_i = 1'b0; r.data_i = '0; r.ready_i = 1'b0;
    endtask

    task automatic apply_reset;
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic push_b(input logic [31:0] base);
        for (int k = 0; k < 32; k++) begin
            b.valid_i = 1'b1;
            b.data_i  = base + k;
            step();
        end
        b.valid_i = 1'b0;
        b.data_i  = '0;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++; if (b.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", b.valid_o); end
        checks++; if (b.data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", b.data_o); end
        checks++; if (b.first_o !== 1'b0 || b.last_o !== 1'b0) begin errors++; $display("FAIL reset_marks got %b%b exp 00", b.first_o, b.last_o); end
        checks++; if (b.ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", b.ovf_o); end
        checks++; if (r.valid_o !== 1'b0 || r.data_o !== 32'h0) begin errors++; $display("FAIL reset_rev got v=%b d=%h exp 0", r.valid_o, r.data_o); end
    endtask

    task automatic test_basic;
        apply_reset();
        b.ready_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            b.valid_i = 1'b1;
            b.data_i  = k;
            checks++; if (b.valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid k=%0d got %b exp 0", k, b.valid_o); end
            step();
        end
        b.valid_i = 1'b0;
        for (int k = 0; k < 32; k++) begin
            checks++; if (b.valid_o !== 1'b1 || b.data_o !== 32'(k)) begin errors++; $display("FAIL basic_data k=%0d got v=%b d=%h exp 1/%h", k, b.valid_o, b.data_o, k); end
            checks++; if (b.first_o !== (k == 0) || b.last_o !== (k == 31)) begin errors++; $display("FAIL basic_marks k=%0d got %b%b", k, b.first_o, b.last_o); end
            step();
        end
        checks++; if (b.valid_o !== 1'b0 || b.ovf_o !== 1'b0) begin errors++; $display("FAIL basic_end got v=%b ovf=%b exp 0/0", b.valid_o, b.ovf_o); end
        b.ready_i = 1'b0;
    endtask

    task automatic test_gaps;
        int n = 0;
        int cyc = 0;
        apply_reset();
        while (n < 32 && cyc < 400) begin
            b.valid_i = ($urandom_range(0, 9) < 7);
            b.data_i  = 32'h300 + n;
            step();
            if (b.valid_i) n++;
            cyc++;
        end
        b.valid_i = 1'b0;
        checks++; if (n != 32) begin errors++; $display("FAIL gaps_write_timeout got %0d words exp 32", n); end
        n = 0;
        cyc = 0;
        while (n < 32 && cyc < 400) begin
            b.ready_i = (cyc % 2 == 0);
            checks++; if (b.valid_o !== 1'b1 || b.data_o !== 32'h300 + n) begin errors++; $display("FAIL gaps_data n=%0d got v=%b d=%h exp 1/%h", n, b.valid_o, b.data_o, 32'h300 + n); end
            checks++; if (b.first_o !== (n == 0) || b.last_o !== (n == 31)) begin errors++; $display("FAIL gaps_marks n=%0d got %b%b", n, b.first_o, b.last_o); end
            step();
            if (b.ready_i) n++;
            cyc++;
        end
        b.ready_i = 1'b0;
        checks++; if (n != 32 || b.valid_o !== 1'b0) begin errors++; $display("FAIL gaps_end got n=%0d v=%b exp 32/0", n, b.valid_o); end
    endtask

    task automatic test_overflow;
        apply_reset();
        push_b(32'h100);
        push_b(32'h200);
        checks++; if (b.ovf_o !== 1'b0 || b.data_o !== 32'h100) begin errors++; $display("FAIL ovf_pre got ovf=%b d=%h exp 0/100", b.ovf_o, b.data_o); end
        b.valid_i = 1'b1;
        b.data_i  = 32'h300;
        step();
        checks++; if (b.ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_first_drop got %b exp 1", b.ovf_o); end
        for (int k = 1; k < 32; k++) begin
            b.data_i = 32'h300 + k;
            step();
        end
        b.valid_i = 1'b0;
        b.ready_i = 1'b1;
        for (int k = 0; k < 64; k++) begin
            logic [31:0] exp_d;
            exp_d = (k < 32) ? 32'h100 + k : 32'h200 + (k - 32);
            checks++; if (b.valid_o !== 1'b1 || b.data_o !== exp_d) begin errors++; $display("FAIL ovf_data k=%0d got v=%b d=%h exp 1/%h", k, b.valid_o, b.data_o, exp_d); end
            step();
        end
        checks++; if (b.valid_o !== 1'b0 || b.ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_end got v=%b ovf=%b exp 0/1", b.valid_o, b.ovf_o); end
        b.ready_i = 1'b0;
    endtask

    task automatic test_rev;
        apply_reset();
        for (int k = 0; k < 32; k++) begin
            r.valid_i = 1'b1;
            r.data_i  = 100 + k;
            step();
        end
        r.valid_i = 1'b0;
        r.ready_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            checks++; if (r.valid_o !== 1'b1 || r.data_o !== 32'(131 - k)) begin errors++; $display("FAIL rev_data k=%0d got v=%b d=%0d exp 1/%0d", k, r.valid_o, r.data_o, 131 - k); end
            checks++; if (r.first_o !== (k == 0) || r.last_o !== (k == 31)) begin errors++; $display("FAIL rev_marks k=%0d got %b%b", k, r.first_o, r.last_o); end
            step();
        end
        checks++; if (r.valid_o !== 1'b0) begin errors++; $display("FAIL rev_end got %b exp 0", r.valid_o); end
        r.ready_i = 1'b0;
    endtask

    task automatic test_async_reset;
        apply_reset();
        push_b(32'h0);
        for (int j = 0; j < 12; j++) begin
            b.valid_i = 1'b1;
            b.data_i  = 32'h40 + j;
            b.ready_i = (j < 5);
            step();
        end
        idle();
        checks++; if (b.data_o !== 32'h5) begin errors++; $display("FAIL arst_pre got %h exp 5", b.data_o); end
        // Drop reset mid-cycle: outputs must clear without waiting for a clock edge
        #2 rst_n = 1'b0;
        #1;
        checks++; if (b.valid_o !== 1'b0 || b.data_o !== 32'h0) begin errors++; $display("FAIL arst_out got v=%b d=%h exp 0/0", b.valid_o, b.data_o); end
        checks++; if (b.first_o !== 1'b0 || b.last_o !== 1'b0 || b.ovf_o !== 1'b0) begin errors++; $display("FAIL arst_flags got %b%b%b exp 000", b.first_o, b.last_o, b.ovf_o); end
        step();
        rst_n = 1'b1;
        push_b(32'hA00);
        b.ready_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            checks++; if (b.valid_o !== 1'b1 || b.data_o !== 32'hA00 + k) begin errors++; $display("FAIL arst_frame k=%0d got v=%b d=%h exp 1/%h", k, b.valid_o, b.data_o, 32'hA00 + k); end
            step();
        end
        checks++; if (b.valid_o !== 1'b0) begin errors++; $display("FAIL arst_end got %b exp 0", b.valid_o); end
        b.ready_i = 1'b0;
    endtask

    task automatic test_simul;
        apply_reset();
        push_b(32'h0);
        push_b(32'h100);
        b.ready_i = 1'b1;
        for (int k = 0; k < 31; k++) step();
        b.valid_i = 1'b1;
        b.data_i  = 32'hBAD;
        checks++; if (b.last_o !== 1'b1 || b.data_o !== 32'd31 || b.ovf_o !== 1'b0) begin errors++; $display("FAIL sim_pre got last=%b d=%h ovf=%b exp 1/1f/0", b.last_o, b.data_o, b.ovf_o); end
        step();
        b.valid_i = 1'b0;
        checks++; if (b.ovf_o !== 1'b1) begin errors++; $display("FAIL sim_ovf got %b exp 1", b.ovf_o); end
        checks++; if (b.valid_o !== 1'b1 || b.data_o !== 32'h100) begin errors++; $display("FAIL sim_swap got v=%b d=%h exp 1/100", b.valid_o, b.data_o); end
        b.ready_i = 1'b0;
        push_b(32'hC0);
        b.ready_i = 1'b1;
        for (int k = 0; k < 64; k++) begin
            logic [31:0] exp_d;
            exp_d = (k < 32) ? 32'h100 + k : 32'hC0 + (k - 32);
            checks++; if (b.valid_o !== 1'b1 || b.data_o !== exp_d) begin errors++; $display("FAIL sim_data k=%0d got v=%b d=%h exp 1/%h", k, b.valid_o, b.data_o, exp_d); end
            step();
        end
        checks++; if (b.valid_o !== 1'b0) begin errors++; $display("FAIL sim_end got %b exp 0", b.valid_o); end
        b.ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_rev();
        test_async_reset();
        test_simul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
